// File: rtl/ecc_pkg.sv
// Shared opcodes, FSM encodings, regfile indices and microcode entry format
// for the EC point add/double sequencer.
package ecc_pkg;

  localparam logic [1:0] GF_ADD  = 2'd0;
  localparam logic [1:0] GF_SUB  = 2'd1;
  localparam logic [1:0] GF_MULT = 2'd2;
  localparam logic [1:0] GF_DIV  = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [3:0] RF_X1 = 4'd0;
  localparam logic [3:0] RF_Y1 = 4'd1;
  localparam logic [3:0] RF_X2 = 4'd2;
  localparam logic [3:0] RF_Y2 = 4'd3;
  localparam logic [3:0] RF_A  = 4'd4;
  localparam logic [3:0] RF_T0 = 4'd5;
  localparam logic [3:0] RF_T1 = 4'd6;
  localparam logic [3:0] RF_L  = 4'd7;
  localparam logic [3:0] RF_X3 = 4'd8;
  localparam logic [3:0] RF_Y3 = 4'd9;
  localparam int         RF_N  = 10;

  localparam logic [3:0] ADD_LEN = 4'd9;
  localparam logic [3:0] DBL_LEN = 4'd12;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] src0;
    logic [3:0] src1;
    logic [3:0] dst;
  } ucode_t;

  // Argument order mirrors the microprogram text: dst = src0 op src1.
  function automatic ucode_t uop(input logic [1:0] op, input logic [3:0] dst,
                                 input logic [3:0] src0, input logic [3:0] src1);
    uop = {op, src0, src1, dst};
  endfunction

endpackage

// File: rtl/ecc_ucode_rom.sv
// Combinational microprogram lookup: (step, mode) -> {op, src0, src1, dst}.
// The doubling table exists only when ECC_DOUBLE_EN is defined.
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  logic [3:0] step,
  input  logic       dbl,
  output ucode_t     entry
);

  ucode_t add_entry;

  always_comb begin
    add_entry = '0;
    case (step)
      4'd0:    add_entry = uop(GF_SUB,  RF_T0, RF_Y2, RF_Y1);
      4'd1:    add_entry = uop(GF_SUB,  RF_T1, RF_X2, RF_X1);
      4'd2:    add_entry = uop(GF_DIV,  RF_L,  RF_T0, RF_T1);
      4'd3:    add_entry = uop(GF_MULT, RF_T0, RF_L,  RF_L);
      4'd4:    add_entry = uop(GF_SUB,  RF_T0, RF_T0, RF_X1);
      4'd5:    add_entry = uop(GF_SUB,  RF_X3, RF_T0, RF_X2);
      4'd6:    add_entry = uop(GF_SUB,  RF_T1, RF_X1, RF_X3);
      4'd7:    add_entry = uop(GF_MULT, RF_T0, RF_L,  RF_T1);
      4'd8:    add_entry = uop(GF_SUB,  RF_Y3, RF_T0, RF_Y1);
      default: add_entry = '0;
    endcase
  end

`ifdef ECC_DOUBLE_EN
  ucode_t dbl_entry;

  always_comb begin
    dbl_entry = '0;
    case (step)
      4'd0:    dbl_entry = uop(GF_MULT, RF_T0, RF_X1, RF_X1);
      4'd1:    dbl_entry = uop(GF_ADD,  RF_T1, RF_T0, RF_T0);
      4'd2:    dbl_entry = uop(GF_ADD,  RF_T0, RF_T1, RF_T0);
      4'd3:    dbl_entry = uop(GF_ADD,  RF_T0, RF_T0, RF_A);
      4'd4:    dbl_entry = uop(GF_ADD,  RF_T1, RF_Y1, RF_Y1);
      4'd5:    dbl_entry = uop(GF_DIV,  RF_L,  RF_T0, RF_T1);
      4'd6:    dbl_entry = uop(GF_MULT, RF_T0, RF_L,  RF_L);
      4'd7:    dbl_entry = uop(GF_ADD,  RF_T1, RF_X1, RF_X1);
      4'd8:    dbl_entry = uop(GF_SUB,  RF_X3, RF_T0, RF_T1);
      4'd9:    dbl_entry = uop(GF_SUB,  RF_T1, RF_X1, RF_X3);
      4'd10:   dbl_entry = uop(GF_MULT, RF_T0, RF_L,  RF_T1);
      4'd11:   dbl_entry = uop(GF_SUB,  RF_Y3, RF_T0, RF_Y1);
      default: dbl_entry = '0;
    endcase
  end

  assign entry = dbl ? dbl_entry : add_entry;
`else
  logic unused_dbl;
  assign unused_dbl = dbl;
  assign entry      = add_entry;
`endif

endmodule

// File: rtl/ecc_point_seq.sv
// Affine EC point add (and doubling when ECC_DOUBLE_EN is defined) sequencer driving one GFAU
// via a start/done handshake; one op in flight, o_done 1 cycle after the last GFAU result.
module ecc_point_seq
  import ecc_pkg::*;
#(
  parameter int SIZE           = 33,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_dbl,
  input  logic [SIZE-1:0] i_x1,
  input  logic [SIZE-1:0] i_y1,
  input  logic [SIZE-1:0] i_x2,
  input  logic [SIZE-1:0] i_y2,
  input  logic [SIZE-1:0] i_a,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_inf,
  output logic            o_err,
  output logic [SIZE-1:0] o_x3,
  output logic [SIZE-1:0] o_y3,
  output logic [1:0]      o_gf_op,
  output logic            o_gf_start,
  output logic [SIZE-1:0] o_gf_in_0,
  output logic [SIZE-1:0] o_gf_in_1,
  input  logic [SIZE-1:0] i_gf_result,
  input  logic            i_gf_done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]      state;
  logic [3:0]      step;
  logic [CW-1:0]   tmo_cnt;
  logic            dbl_mode;
  logic [SIZE-1:0] rf [RF_N];
  ucode_t          ent;
  logic [3:0]      prog_len;
  logic            last_step;
  logic            gf_act;

  ecc_ucode_rom u_rom (
    .step  (step),
    .dbl   (dbl_mode),
    .entry (ent)
  );

`ifndef ECC_DOUBLE_EN
  logic unused_dbl;
  assign unused_dbl = i_dbl;
`endif

  assign prog_len  = dbl_mode ? DBL_LEN : ADD_LEN;
  assign last_step = (step == prog_len - 4'd1);
  assign gf_act    = (state == ST_ISSUE) || (state == ST_WAIT);

  // Operands come straight from the regfile; nothing they read is written until the op retires.
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_FINISH);
  assign o_gf_start = (state == ST_ISSUE);
  assign o_gf_op    = gf_act ? ent.op         : 2'd0;
  assign o_gf_in_0  = gf_act ? rf[ent.src0]   : '0;
  assign o_gf_in_1  = gf_act ? rf[ent.src1]   : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      step     <= '0;
      tmo_cnt  <= '0;
      dbl_mode <= 1'b0;
      o_inf    <= 1'b0;
      o_err    <= 1'b0;
      o_x3     <= '0;
      o_y3     <= '0;
      for (int i = 0; i < RF_N; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rf[RF_X1] <= i_x1;
            rf[RF_Y1] <= i_y1;
            rf[RF_X2] <= i_x2;
            rf[RF_Y2] <= i_y2;
            rf[RF_A]  <= i_a;
            step      <= '0;
            o_inf     <= 1'b0;
            o_err     <= 1'b0;
`ifdef ECC_DOUBLE_EN
            dbl_mode  <= i_dbl;
`else
            dbl_mode  <= 1'b0;
`endif
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!dbl_mode && rf[RF_X1] == rf[RF_X2]) begin
            if (rf[RF_Y1] != rf[RF_Y2]) begin
              o_inf <= 1'b1;
              state <= ST_FINISH;
            end else begin
`ifdef ECC_DOUBLE_EN
              // P == Q: fall over to doubling; a zero y doubles to infinity.
              if (rf[RF_Y1] == '0) begin
                o_inf <= 1'b1;
                state <= ST_FINISH;
              end else begin
                dbl_mode <= 1'b1;
                state    <= ST_ISSUE;
              end
`else
              o_inf <= 1'b1;
              o_err <= 1'b1;
              state <= ST_FINISH;
`endif
            end
          end else if (dbl_mode && rf[RF_Y1] == '0) begin
            o_inf <= 1'b1;
            state <= ST_FINISH;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_gf_done) begin
            rf[ent.dst] <= i_gf_result;
            step        <= step + 4'd1;
            if (last_step) begin
              o_x3  <= (ent.dst == RF_X3) ? i_gf_result : rf[RF_X3];
              o_y3  <= (ent.dst == RF_Y3) ? i_gf_result : rf[RF_Y3];
              state <= ST_FINISH;
            end else begin
              state <= ST_ISSUE;
            end
          end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            o_err <= 1'b1;
            state <= ST_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_seq.sv
// Directed bench for ecc_point_seq over p=23, a=1 with a behavioural GFAU of random latency.
module tb_ecc_point_seq;

  localparam int P    = 23;
  localparam int TMO  = 1023;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_dbl = 1'b0;
  logic [32:0] i_x1 = '0, i_y1 = '0, i_x2 = '0, i_y2 = '0;
  logic [32:0] i_a = 33'd1;
  logic        o_busy, o_done, o_inf, o_err, o_gf_start;
  logic [32:0] o_x3, o_y3, o_gf_in_0, o_gf_in_1;
  logic [1:0]  o_gf_op;
  logic [32:0] i_gf_result = '0;
  logic        gf_done_m = 1'b0;
  logic        gf_stray = 1'b0;
  logic        gf_mute = 1'b0;
  logic        i_gf_done;

  assign i_gf_done = gf_done_m | gf_stray;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int gf_cnt = 0;
  int done_cnt = 0;
  int last_issue = 0;

  logic [32:0] r_x3, r_y3, r_inf, r_err, r_ops;
  int          r_cyc;

  ecc_point_seq #(.SIZE(33), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_dbl       (i_dbl),
    .i_x1        (i_x1),
    .i_y1        (i_y1),
    .i_x2        (i_x2),
    .i_y2        (i_y2),
    .i_a         (i_a),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_inf       (o_inf),
    .o_err       (o_err),
    .o_x3        (o_x3),
    .o_y3        (o_y3),
    .o_gf_op     (o_gf_op),
    .o_gf_start  (o_gf_start),
    .o_gf_in_0   (o_gf_in_0),
    .o_gf_in_1   (o_gf_in_1),
    .i_gf_result (i_gf_result),
    .i_gf_done   (i_gf_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_gf_start) begin
      gf_cnt     <= gf_cnt + 1;
      last_issue <= cyc;
    end
    if (o_done) done_cnt <= done_cnt + 1;
  end

  function automatic int gf_calc(input logic [1:0] op, input int a, input int b);
    int inv;
    case (op)
      2'd0:    return (a + b) % P;
      2'd1:    return (a - b + P) % P;
      2'd2:    return (a * b) % P;
      default: begin
        inv = 0;
        for (int k = 1; k < P; k++) if ((b * k) % P == 1) inv = k;
        return (a * inv) % P;
      end
    endcase
  endfunction

  // Behavioural GFAU: grabs operands on the start pulse, answers 1..40 cycles later.
  initial begin
    int a, b, r, lat;
    logic [1:0] op;
    forever begin
      @(posedge i_clk); #1;
      while (o_gf_start && !gf_mute) begin
        a   = int'(o_gf_in_0);
        b   = int'(o_gf_in_1);
        op  = o_gf_op;
        r   = gf_calc(op, a, b);
        lat = int'($urandom_range(40, 1));
        repeat (lat) @(posedge i_clk);
        #1;
        gf_done_m   = 1'b1;
        i_gf_result = 33'(r);
        @(posedge i_clk); #1;
        gf_done_m = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input int x1, input int y1, input int x2, input int y2,
                        input logic dbl, input bit poke, input int budget);
    int t;
    int base;
    @(negedge i_clk);
    i_x1 = 33'(x1); i_y1 = 33'(y1); i_x2 = 33'(x2); i_y2 = 33'(y2);
    i_dbl = dbl; i_start = 1'b1; base = gf_cnt;
    @(negedge i_clk);
    i_start = 1'b0;
    t = 0;
    while (!o_done && t < budget) begin
      @(negedge i_clk);
      t++;
      if (poke && t == 20) begin
        i_start = 1'b1; i_x1 = '0; i_y1 = '0;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    if (!o_done) check("done_seen", 33'(o_done), 33'd1);
    r_x3  = o_x3;
    r_y3  = o_y3;
    r_inf = 33'(o_inf);
    r_err = 33'(o_err);
    r_ops = 33'(gf_cnt - base);
    r_cyc = cyc;
    @(negedge i_clk);
    check("busy_after", 33'(o_busy), 33'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge i_clk);
    check("rst_busy",  33'(o_busy), 33'd0);
    check("rst_done",  33'(o_done), 33'd0);
    check("rst_x3",    o_x3, 33'd0);
    check("rst_inf",   33'(o_inf), 33'd0);
    check("rst_gfst",  33'(o_gf_start), 33'd0);
    check("rst_gfin0", o_gf_in_0, 33'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // P + Q on y^2 = x^3 + x + 1 mod 23
    run_op(3, 10, 9, 7, 1'b0, 1'b0, 2000);
    check("add_x3", r_x3, 33'd17);
    check("add_y3", r_y3, 33'd20);
    check("add_inf", r_inf, 33'd0);
    check("add_err", r_err, 33'd0);
    check("add_ops", r_ops, 33'd9);

    // Swapped operands with an ignored i_start mid-operation
    run_op(9, 7, 3, 10, 1'b0, 1'b1, 2000);
    check("poke_x3", r_x3, 33'd17);
    check("poke_y3", r_y3, 33'd20);
    check("poke_ops", r_ops, 33'd9);

    // Inverse points: infinity, no GFAU traffic, result held
    run_op(3, 10, 3, 13, 1'b0, 1'b0, 100);
    check("inv_inf", r_inf, 33'd1);
    check("inv_err", r_err, 33'd0);
    check("inv_ops", r_ops, 33'd0);
    check("inv_x3_held", r_x3, 33'd17);

    run_op(3, 10, 9, 7, 1'b1, 1'b0, 2000);
`ifdef ECC_DOUBLE_EN
    check("dbl_x3", r_x3, 33'd7);
    check("dbl_y3", r_y3, 33'd12);
    check("dbl_ops", r_ops, 33'd12);
`else
    check("dblign_x3", r_x3, 33'd17);
    check("dblign_y3", r_y3, 33'd20);
    check("dblign_ops", r_ops, 33'd9);
`endif

    run_op(3, 10, 3, 10, 1'b0, 1'b0, 2000);
`ifdef ECC_DOUBLE_EN
    check("peq_x3", r_x3, 33'd7);
    check("peq_y3", r_y3, 33'd12);
    check("peq_inf", r_inf, 33'd0);
    check("peq_ops", r_ops, 33'd12);
`else
    check("peq_inf", r_inf, 33'd1);
    check("peq_err", r_err, 33'd1);
    check("peq_ops", r_ops, 33'd0);
`endif

    run_op(0, 1, 3, 10, 1'b0, 1'b0, 2000);
    check("add2_x3", r_x3, 33'd6);
    check("add2_y3", r_y3, 33'd4);
    check("add2_inf", r_inf, 33'd0);

`ifdef ECC_DOUBLE_EN
    run_op(5, 0, 9, 7, 1'b1, 1'b0, 100);
    check("dbly0_inf", r_inf, 33'd1);
    check("dbly0_ops", r_ops, 33'd0);
    check("dbly0_x3_held", r_x3, 33'd6);
`endif

    // Silent GFAU: timeout after exactly TMO+1 cycles from the issue cycle
    gf_mute = 1'b1;
    run_op(3, 10, 9, 7, 1'b0, 1'b0, 3000);
    gf_mute = 1'b0;
    check("tmo_err", r_err, 33'd1);
    check("tmo_inf", r_inf, 33'd0);
    check("tmo_ops", r_ops, 33'd1);
    check("tmo_lat", 33'(r_cyc - last_issue), 33'(TMO + 1));
    check("tmo_x3_held", r_x3, 33'd6);

    // Stray GFAU done while idle
    base = done_cnt;
    @(negedge i_clk); gf_stray = 1'b1;
    @(negedge i_clk); gf_stray = 1'b0;
    check("stray_busy", 33'(o_busy), 33'd0);
    repeat (3) @(negedge i_clk);
    check("stray_done", 33'(done_cnt - base), 33'd0);

    // Reset in the middle of an operation
    @(negedge i_clk);
    i_x1 = 33'd3; i_y1 = 33'd10; i_x2 = 33'd9; i_y2 = 33'd7; i_dbl = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    repeat (15) @(negedge i_clk);
    check("mid_busy", 33'(o_busy), 33'd1);
    i_rst = 1'b1;
    base = done_cnt;
    @(negedge i_clk);
    check("mrst_busy", 33'(o_busy), 33'd0);
    check("mrst_gfst", 33'(o_gf_start), 33'd0);
    check("mrst_gfop", 33'(o_gf_op), 33'd0);
    check("mrst_x3", o_x3, 33'd0);
    check("mrst_y3", o_y3, 33'd0);
    check("mrst_err", 33'(o_err), 33'd0);
    i_rst = 1'b0;
    repeat (60) @(negedge i_clk);
    check("mrst_no_done", 33'(done_cnt - base), 33'd0);

    run_op(0, 1, 3, 10, 1'b0, 1'b0, 2000);
    check("post_x3", r_x3, 33'd6);
    check("post_y3", r_y3, 33'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
